// File: rtl/ifm_frame_sched.sv
// Frame scheduler for the s2mm receive path: pops a per-frame verdict, forwards good
// frames to the good FIFO followed by a 4-word status record, drains bad frames.
module ifm_frame_sched #(
  parameter logic [31:0] C_STS_TAG = 32'h5000_0000,
  parameter int          C_CNT_W   = 32
) (
  input  logic               s2mm_clk,
  input  logic               s2mm_reset,
  input  logic [72:0]        data_fifo_rdata,
  input  logic               data_fifo_empty,
  output logic               data_fifo_rden,
  input  logic [7:0]         info_fifo_rdata,
  input  logic               info_fifo_empty,
  output logic               info_fifo_rden,
  output logic [72:0]        good_fifo_wdata,
  output logic               good_fifo_wren,
  input  logic               good_fifo_afull,
  output logic [36:0]        ctrl_fifo_wdata,
  output logic               ctrl_fifo_wren,
  input  logic               ctrl_fifo_afull,
  output logic [C_CNT_W-1:0] rx_good_cnt,
  output logic [C_CNT_W-1:0] rx_drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP, STS} state_t;

  localparam logic [C_CNT_W-1:0] CNT_ONE = 1;

  state_t              state_reg, state_next;
  logic [7:0]          info_reg;
  logic [15:0]         byte_cnt_reg;
  logic [15:0]         seq_reg;
  logic [1:0]          word_idx_reg;
  logic [72:0]         good_wdata_reg;
  logic                good_wren_reg;
  logic [36:0]         ctrl_wdata_reg;
  logic                ctrl_wren_reg;
  logic [C_CNT_W-1:0]  good_cnt_reg;
  logic [C_CNT_W-1:0]  drop_cnt_reg;

  logic                info_pop;
  logic                data_pop;
  logic                sts_wr;
  logic                beat_last;
  logic [3:0]          keep_bytes;
  logic [16:0]         byte_sum;
  logic [15:0]         byte_cnt_sat;
  logic [31:0]         sts_word;

  assign beat_last = data_fifo_rdata[72];

  always_comb begin
    keep_bytes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      keep_bytes = keep_bytes + {3'b000, data_fifo_rdata[64+i]};
    end
  end

  assign byte_sum     = {1'b0, byte_cnt_reg} + {13'b0, keep_bytes};
  assign byte_cnt_sat = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

  // A good verdict is only consumed once both downstream FIFOs can take a whole
  // burst; a bad verdict never waits because it produces no downstream writes.
  always_comb begin
    state_next = state_reg;
    info_pop   = 1'b0;
    data_pop   = 1'b0;
    sts_wr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!info_fifo_empty) begin
          if (info_fifo_rdata[0]) begin
            if (!good_fifo_afull && !ctrl_fifo_afull) begin
              info_pop   = 1'b1;
              state_next = FWD;
            end
          end else begin
            info_pop   = 1'b1;
            state_next = DROP;
          end
        end
      end
      FWD: begin
        data_pop = !data_fifo_empty && !good_fifo_afull;
        if (data_pop && beat_last) state_next = STS;
      end
      DROP: begin
        data_pop = !data_fifo_empty;
        if (data_pop && beat_last) state_next = IDLE;
      end
      STS: begin
        sts_wr = !ctrl_fifo_afull;
        if (sts_wr && word_idx_reg == 2'd3) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (s2mm_reset) begin
      info_pop   = 1'b0;
      data_pop   = 1'b0;
      sts_wr     = 1'b0;
      state_next = IDLE;
    end
  end

  always_comb begin
    case (word_idx_reg)
      2'd0:    sts_word = C_STS_TAG;
      2'd1:    sts_word = {24'h0, info_reg};
      2'd2:    sts_word = {16'h0, byte_cnt_reg};
      default: sts_word = {16'h0, seq_reg};
    endcase
  end

  always_ff @(posedge s2mm_clk) begin
    if (s2mm_reset) begin
      state_reg      <= IDLE;
      info_reg       <= 8'h00;
      byte_cnt_reg   <= 16'h0000;
      seq_reg        <= 16'h0000;
      word_idx_reg   <= 2'd0;
      good_wdata_reg <= '0;
      good_wren_reg  <= 1'b0;
      ctrl_wdata_reg <= '0;
      ctrl_wren_reg  <= 1'b0;
      good_cnt_reg   <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      good_wren_reg <= 1'b0;
      ctrl_wren_reg <= 1'b0;
      if (info_pop) begin
        info_reg <= info_fifo_rdata;
        if (info_fifo_rdata[0]) byte_cnt_reg <= 16'h0000;
      end
      if (state_reg == FWD && data_pop) begin
        good_wren_reg  <= 1'b1;
        good_wdata_reg <= data_fifo_rdata;
        byte_cnt_reg   <= byte_cnt_sat;
      end
      if (state_reg == DROP && data_pop && beat_last) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
      end
      if (sts_wr) begin
        ctrl_wren_reg  <= 1'b1;
        ctrl_wdata_reg <= {(word_idx_reg == 2'd3), 4'hF, sts_word};
        word_idx_reg   <= word_idx_reg + 2'd1;
        if (word_idx_reg == 2'd3) begin
          seq_reg      <= seq_reg + 16'd1;
          good_cnt_reg <= good_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign data_fifo_rden  = data_pop;
  assign info_fifo_rden  = info_pop;
  assign good_fifo_wdata = good_wdata_reg;
  assign good_fifo_wren  = good_wren_reg;
  assign ctrl_fifo_wdata = ctrl_wdata_reg;
  assign ctrl_fifo_wren  = ctrl_wren_reg;
  assign rx_good_cnt     = good_cnt_reg;
  assign rx_drop_cnt     = drop_cnt_reg;

endmodule

// File: tb/tb_ifm_frame_sched.sv
// Directed bench for ifm_frame_sched: FWFT FIFO models on the read side, capture
// queues on the write side, one task per scenario with inline checks.
module tb_ifm_frame_sched;

  logic        s2mm_clk = 1'b0;
  logic        s2mm_reset = 1'b1;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_empty;
  logic        info_fifo_rden;
  logic [72:0] good_fifo_wdata;
  logic        good_fifo_wren;
  logic        good_fifo_afull = 1'b0;
  logic [36:0] ctrl_fifo_wdata;
  logic        ctrl_fifo_wren;
  logic        ctrl_fifo_afull = 1'b0;
  logic [31:0] rx_good_cnt;
  logic [31:0] rx_drop_cnt;

  ifm_frame_sched dut (
    .s2mm_clk        (s2mm_clk),
    .s2mm_reset      (s2mm_reset),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rden  (info_fifo_rden),
    .good_fifo_wdata (good_fifo_wdata),
    .good_fifo_wren  (good_fifo_wren),
    .good_fifo_afull (good_fifo_afull),
    .ctrl_fifo_wdata (ctrl_fifo_wdata),
    .ctrl_fifo_wren  (ctrl_fifo_wren),
    .ctrl_fifo_afull (ctrl_fifo_afull),
    .rx_good_cnt     (rx_good_cnt),
    .rx_drop_cnt     (rx_drop_cnt)
  );

  always #5 s2mm_clk = ~s2mm_clk;

  logic [72:0] dq[$];
  logic [7:0]  iq[$];
  logic [72:0] gq[$];
  int          gcyc[$];
  logic [36:0] cq[$];
  int          ccyc[$];
  int          ipop_cyc[$];
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          afull_pop_viol = 0;
  int          total = 0;
  int          bad = 0;

  logic        m_dpop, m_ipop;
  logic [72:0] m_head;
  logic [7:0]  m_info;
  int          m_cyc;

  task automatic refresh();
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = (dq.size() == 0) ? 73'h0 : dq[0];
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = (iq.size() == 0) ? 8'h00 : iq[0];
  endtask

  always @(posedge s2mm_clk) cyc <= cyc + 1;

  // Pop requests are sampled at the edge, the FIFO head advances just after it.
  always @(posedge s2mm_clk) begin
    m_dpop = data_fifo_rden;
    m_ipop = info_fifo_rden;
    m_cyc  = cyc;
    if (m_dpop && good_fifo_afull) afull_pop_viol++;
    #1;
    if (m_dpop && dq.size() > 0) begin
      m_head = dq.pop_front();
      if (m_head[72]) last_pop_cyc = m_cyc;
    end
    if (m_ipop && iq.size() > 0) begin
      m_info = iq.pop_front();
      ipop_cyc.push_back(m_cyc);
    end
    refresh();
  end

  always @(negedge s2mm_clk) begin
    if (good_fifo_wren) begin
      gq.push_back(good_fifo_wdata);
      gcyc.push_back(cyc);
    end
    if (ctrl_fifo_wren) begin
      cq.push_back(ctrl_fifo_wdata);
      ccyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge s2mm_clk);
    #1;
  endtask

  function automatic logic [36:0] sts(input logic tl, input logic [31:0] w);
    return {tl, 4'hF, w};
  endfunction

  function automatic logic [72:0] beat(input logic tl, input logic [7:0] k, input logic [63:0] d);
    return {tl, k, d};
  endfunction

  task automatic clear_caps();
    gq.delete(); gcyc.delete(); cq.delete(); ccyc.delete(); ipop_cyc.delete();
  endtask

  task automatic push_frame(input logic [7:0] info, input int n, input logic [7:0] last_keep,
                            input logic [63:0] seed);
    for (int i = 0; i < n; i++) begin
      dq.push_back(beat(i == n - 1, (i == n - 1) ? last_keep : 8'hFF, seed + 64'(i)));
    end
    iq.push_back(info);
    refresh();
  endtask

  task automatic do_reset();
    s2mm_reset = 1'b1;
    good_fifo_afull = 1'b0;
    ctrl_fifo_afull = 1'b0;
    dq.delete(); iq.delete();
    refresh();
    tick(); tick();
    s2mm_reset = 1'b0;
    clear_caps();
  endtask

  task automatic wait_ctrl(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    s2mm_reset = 1'b1;
    push_frame(8'h01, 1, 8'hFF, 64'h0);
    tick(); tick();
    total++; if (data_fifo_rden !== 1'b0) begin bad++; $display("FAIL rst_data_rden got=%b want=0", data_fifo_rden); end
    total++; if (info_fifo_rden !== 1'b0) begin bad++; $display("FAIL rst_info_rden got=%b want=0", info_fifo_rden); end
    total++; if (good_fifo_wren !== 1'b0) begin bad++; $display("FAIL rst_good_wren got=%b want=0", good_fifo_wren); end
    total++; if (good_fifo_wdata !== 73'h0) begin bad++; $display("FAIL rst_good_wdata got=%h want=0", good_fifo_wdata); end
    total++; if (ctrl_fifo_wren !== 1'b0) begin bad++; $display("FAIL rst_ctrl_wren got=%b want=0", ctrl_fifo_wren); end
    total++; if (ctrl_fifo_wdata !== 37'h0) begin bad++; $display("FAIL rst_ctrl_wdata got=%h want=0", ctrl_fifo_wdata); end
    total++; if (rx_good_cnt !== 32'h0) begin bad++; $display("FAIL rst_good_cnt got=%0d want=0", rx_good_cnt); end
    total++; if (rx_drop_cnt !== 32'h0) begin bad++; $display("FAIL rst_drop_cnt got=%0d want=0", rx_drop_cnt); end
    total++; if (iq.size() !== 1) begin bad++; $display("FAIL rst_no_pop got=%0d want=1 pending info", iq.size()); end
    $display("test_reset: done");
  endtask

  task automatic test_good_frame();
    bit ok;
    do_reset();
    push_frame(8'h03, 3, 8'h0F, 64'h1000);
    wait_ctrl(4, 60, ok);
    tick(); tick(); tick();
    total++; if (!ok) begin bad++; $display("FAIL good_timeout got=%0d want=4 status words", cq.size()); end
    total++; if (gq.size() !== 3) begin bad++; $display("FAIL good_beats got=%0d want=3", gq.size()); end
    for (int i = 0; i < 3 && i < gq.size(); i++) begin
      total++;
      if (gq[i] !== beat(i == 2, (i == 2) ? 8'h0F : 8'hFF, 64'h1000 + 64'(i))) begin
        bad++; $display("FAIL good_beat%0d got=%h", i, gq[i]);
      end
    end
    total++; if (cq.size() !== 4) begin bad++; $display("FAIL good_sts_cnt got=%0d want=4", cq.size()); end
    if (cq.size() == 4) begin
      total++; if (cq[0] !== sts(1'b0, 32'h5000_0000)) begin bad++; $display("FAIL good_w0 got=%h want=%h", cq[0], sts(1'b0, 32'h5000_0000)); end
      total++; if (cq[1] !== sts(1'b0, 32'h0000_0003)) begin bad++; $display("FAIL good_w1 got=%h want=%h", cq[1], sts(1'b0, 32'h3)); end
      total++; if (cq[2] !== sts(1'b0, 32'h0000_0014)) begin bad++; $display("FAIL good_w2 got=%h want=%h", cq[2], sts(1'b0, 32'h14)); end
      total++; if (cq[3] !== sts(1'b1, 32'h0000_0000)) begin bad++; $display("FAIL good_w3 got=%h want=%h", cq[3], sts(1'b1, 32'h0)); end
      total++; if (ccyc[0] - last_pop_cyc !== 2) begin bad++; $display("FAIL good_w0_lat got=%0d want=2", ccyc[0] - last_pop_cyc); end
      total++; if (ccyc[3] - last_pop_cyc !== 5) begin bad++; $display("FAIL good_w3_lat got=%0d want=5", ccyc[3] - last_pop_cyc); end
    end
    if (gcyc.size() > 0 && ipop_cyc.size() > 0) begin
      total++; if (gcyc[0] - ipop_cyc[0] !== 2) begin bad++; $display("FAIL good_first_lat got=%0d want=2", gcyc[0] - ipop_cyc[0]); end
    end
    total++; if (rx_good_cnt !== 32'd1) begin bad++; $display("FAIL good_cnt got=%0d want=1", rx_good_cnt); end
    total++; if (rx_drop_cnt !== 32'd0) begin bad++; $display("FAIL good_drop_cnt got=%0d want=0", rx_drop_cnt); end
    $display("test_good_frame: done");
  endtask

  task automatic test_drop_then_good();
    bit ok;
    do_reset();
    push_frame(8'h00, 4, 8'hFF, 64'h2000);
    push_frame(8'h01, 1, 8'h07, 64'h3000);
    wait_ctrl(4, 60, ok);
    tick(); tick(); tick();
    total++; if (!ok) begin bad++; $display("FAIL drop_timeout got=%0d want=4 status words", cq.size()); end
    total++; if (rx_drop_cnt !== 32'd1) begin bad++; $display("FAIL drop_cnt got=%0d want=1", rx_drop_cnt); end
    total++; if (rx_good_cnt !== 32'd1) begin bad++; $display("FAIL drop_good_cnt got=%0d want=1", rx_good_cnt); end
    total++; if (gq.size() !== 1) begin bad++; $display("FAIL drop_beats got=%0d want=1", gq.size()); end
    if (gq.size() > 0) begin
      total++; if (gq[0] !== beat(1'b1, 8'h07, 64'h3000)) begin bad++; $display("FAIL drop_fwd_beat got=%h", gq[0]); end
    end
    total++; if (cq.size() !== 4) begin bad++; $display("FAIL drop_sts_cnt got=%0d want=4", cq.size()); end
    if (cq.size() == 4) begin
      total++; if (cq[1] !== sts(1'b0, 32'h1)) begin bad++; $display("FAIL drop_w1 got=%h want=%h", cq[1], sts(1'b0, 32'h1)); end
      total++; if (cq[2] !== sts(1'b0, 32'h3)) begin bad++; $display("FAIL drop_w2 got=%h want=%h", cq[2], sts(1'b0, 32'h3)); end
      total++; if (cq[3] !== sts(1'b1, 32'h0)) begin bad++; $display("FAIL drop_seq got=%h want=%h", cq[3], sts(1'b1, 32'h0)); end
    end
    if (ipop_cyc.size() == 2) begin
      total++; if (ipop_cyc[1] - ipop_cyc[0] !== 5) begin bad++; $display("FAIL drop_next_pop got=%0d want=5", ipop_cyc[1] - ipop_cyc[0]); end
    end else begin
      total++; bad++; $display("FAIL drop_info_pops got=%0d want=2", ipop_cyc.size());
    end
    $display("test_drop_then_good: done");
  endtask

  task automatic test_afull_idle();
    bit ok;
    do_reset();
    good_fifo_afull = 1'b1;
    push_frame(8'h01, 1, 8'hFF, 64'h4000);
    repeat (8) tick();
    total++; if (ipop_cyc.size() !== 0) begin bad++; $display("FAIL afidle_pop got=%0d want=0", ipop_cyc.size()); end
    total++; if (iq.size() !== 1) begin bad++; $display("FAIL afidle_pending got=%0d want=1", iq.size()); end
    good_fifo_afull = 1'b0;
    wait_ctrl(4, 40, ok);
    tick(); tick();
    total++; if (rx_good_cnt !== 32'd1) begin bad++; $display("FAIL afidle_good got=%0d want=1", rx_good_cnt); end
    good_fifo_afull = 1'b1;
    push_frame(8'h00, 2, 8'hFF, 64'h5000);
    for (int i = 0; i < 20; i++) begin
      if (rx_drop_cnt == 32'd1) break;
      tick();
    end
    total++; if (rx_drop_cnt !== 32'd1) begin bad++; $display("FAIL afidle_drop got=%0d want=1", rx_drop_cnt); end
    total++; if (gq.size() !== 1) begin bad++; $display("FAIL afidle_drop_wr got=%0d want=1", gq.size()); end
    total++; if (dq.size() !== 0) begin bad++; $display("FAIL afidle_drained got=%0d want=0", dq.size()); end
    good_fifo_afull = 1'b0;
    $display("test_afull_idle: done");
  endtask

  task automatic test_afull_toggle();
    bit ok;
    do_reset();
    push_frame(8'h01, 8, 8'hFF, 64'h6000);
    afull_pop_viol = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      good_fifo_afull = (i % 2 == 1);
      if (cq.size() >= 4) break;
    end
    good_fifo_afull = 1'b0;
    wait_ctrl(4, 20, ok);
    tick();
    total++; if (!ok) begin bad++; $display("FAIL tog_timeout got=%0d want=4 status words", cq.size()); end
    total++; if (afull_pop_viol !== 0) begin bad++; $display("FAIL tog_pop_on_afull got=%0d want=0", afull_pop_viol); end
    total++; if (gq.size() !== 8) begin bad++; $display("FAIL tog_beats got=%0d want=8", gq.size()); end
    for (int i = 0; i < 8 && i < gq.size(); i++) begin
      total++;
      if (gq[i] !== beat(i == 7, 8'hFF, 64'h6000 + 64'(i))) begin bad++; $display("FAIL tog_beat%0d got=%h", i, gq[i]); end
    end
    if (cq.size() == 4) begin
      total++; if (cq[2] !== sts(1'b0, 32'd64)) begin bad++; $display("FAIL tog_bytes got=%h want=%h", cq[2], sts(1'b0, 32'd64)); end
    end
    $display("test_afull_toggle: done");
  endtask

  task automatic test_ctrl_afull();
    bit ok;
    do_reset();
    push_frame(8'h05, 2, 8'h03, 64'h7000);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cq.size() >= 2) break;
    end
    ctrl_fifo_afull = 1'b1;
    repeat (6) tick();
    total++; if (cq.size() !== 2) begin bad++; $display("FAIL cafull_hold got=%0d want=2", cq.size()); end
    ctrl_fifo_afull = 1'b0;
    wait_ctrl(4, 20, ok);
    repeat (4) tick();
    total++; if (cq.size() !== 4) begin bad++; $display("FAIL cafull_cnt got=%0d want=4", cq.size()); end
    if (cq.size() == 4) begin
      total++; if (cq[0] !== sts(1'b0, 32'h5000_0000)) begin bad++; $display("FAIL cafull_w0 got=%h", cq[0]); end
      total++; if (cq[1] !== sts(1'b0, 32'h5)) begin bad++; $display("FAIL cafull_w1 got=%h want=%h", cq[1], sts(1'b0, 32'h5)); end
      total++; if (cq[2] !== sts(1'b0, 32'd10)) begin bad++; $display("FAIL cafull_w2 got=%h want=%h", cq[2], sts(1'b0, 32'd10)); end
      total++; if (cq[3] !== sts(1'b1, 32'h0)) begin bad++; $display("FAIL cafull_w3 got=%h want=%h", cq[3], sts(1'b1, 32'h0)); end
    end
    total++; if (rx_good_cnt !== 32'd1) begin bad++; $display("FAIL cafull_good got=%0d want=1", rx_good_cnt); end
    $display("test_ctrl_afull: done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push_frame(8'h01, 1, 8'hFF, 64'h8000);
    wait_ctrl(4, 40, ok);
    tick(); tick();
    push_frame(8'h01, 10, 8'hFF, 64'h9000);
    for (int i = 0; i < 40; i++) begin
      if (gq.size() >= 5) break;
      tick();
    end
    total++; if (gq.size() < 5) begin bad++; $display("FAIL rmid_progress got=%0d want>=5", gq.size()); end
    s2mm_reset = 1'b1;
    tick();
    total++; if (data_fifo_rden !== 1'b0) begin bad++; $display("FAIL rmid_data_rden got=%b want=0", data_fifo_rden); end
    total++; if (info_fifo_rden !== 1'b0) begin bad++; $display("FAIL rmid_info_rden got=%b want=0", info_fifo_rden); end
    total++; if (good_fifo_wren !== 1'b0 || good_fifo_wdata !== 73'h0) begin bad++; $display("FAIL rmid_good got=%b/%h want=0/0", good_fifo_wren, good_fifo_wdata); end
    total++; if (ctrl_fifo_wren !== 1'b0 || ctrl_fifo_wdata !== 37'h0) begin bad++; $display("FAIL rmid_ctrl got=%b/%h want=0/0", ctrl_fifo_wren, ctrl_fifo_wdata); end
    total++; if (rx_good_cnt !== 32'd0) begin bad++; $display("FAIL rmid_good_cnt got=%0d want=0", rx_good_cnt); end
    total++; if (rx_drop_cnt !== 32'd0) begin bad++; $display("FAIL rmid_drop_cnt got=%0d want=0", rx_drop_cnt); end
    dq.delete(); iq.delete();
    refresh();
    tick();
    s2mm_reset = 1'b0;
    clear_caps();
    push_frame(8'h01, 1, 8'h0F, 64'hA000);
    wait_ctrl(4, 40, ok);
    tick(); tick();
    total++; if (gq.size() !== 1) begin bad++; $display("FAIL rmid_beats got=%0d want=1", gq.size()); end
    if (gq.size() > 0) begin
      total++; if (gq[0] !== beat(1'b1, 8'h0F, 64'hA000)) begin bad++; $display("FAIL rmid_beat got=%h", gq[0]); end
    end
    total++; if (cq.size() !== 4) begin bad++; $display("FAIL rmid_sts_cnt got=%0d want=4", cq.size()); end
    if (cq.size() == 4) begin
      total++; if (cq[2] !== sts(1'b0, 32'd4)) begin bad++; $display("FAIL rmid_bytes got=%h want=%h", cq[2], sts(1'b0, 32'd4)); end
      total++; if (cq[3] !== sts(1'b1, 32'h0)) begin bad++; $display("FAIL rmid_seq got=%h want=%h", cq[3], sts(1'b1, 32'h0)); end
    end
    total++; if (rx_good_cnt !== 32'd1) begin bad++; $display("FAIL rmid_good_after got=%0d want=1", rx_good_cnt); end
    $display("test_reset_mid: done");
  endtask

  initial begin
    refresh();
    test_reset();
    test_good_frame();
    test_drop_then_good();
    test_afull_idle();
    test_afull_toggle();
    test_ctrl_afull();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifm_frame_sched.md
# ifm_frame_sched

Frame scheduler on the s2mm side of the 10GE receive path. It pops one per-frame status byte from the info FIFO and acts on the verdict. A good frame is moved beat by beat from the async data FIFO into the good FIFO (rxd stream), and a 4-word status record is then written to the ctrl FIFO (rxs stream). A bad frame is drained from the data FIFO and discarded. It is the only reader of the data and info FIFOs and the only writer of the good and ctrl FIFOs.

## Interface
Parameters:
- C_STS_TAG, 32'h5000_0000, constant placed in status word 0
- C_CNT_W, 32, width of the good/drop frame counters

Ports:
- s2mm_clk  in  1  single clock for all logic
- s2mm_reset  in  1  synchronous, active-high reset
- data_fifo_rdata  in  73  FWFT head: [72] tlast, [71:64] tkeep, [63:0] data
- data_fifo_empty  in  1  data FIFO empty
- data_fifo_rden  out  1  pop data FIFO head
- info_fifo_rdata  in  8  FWFT head: [0] good, [7:1] flags passed to status
- info_fifo_empty  in  1  info FIFO empty
- info_fifo_rden  out  1  pop info FIFO head
- good_fifo_wdata  out  73  same packing as data_fifo_rdata
- good_fifo_wren  out  1  write good FIFO
- good_fifo_afull  in  1  good FIFO prog_full
- ctrl_fifo_wdata  out  37  [36] tlast, [35:32] tkeep, [31:0] data
- ctrl_fifo_wren  out  1  write ctrl FIFO
- ctrl_fifo_afull  in  1  ctrl FIFO prog_full
- rx_good_cnt  out  C_CNT_W  frames forwarded, wraps
- rx_drop_cnt  out  C_CNT_W  frames dropped, wraps

## Operation
- States: IDLE, FWD, DROP, STS.
- IDLE: the block waits for ~info_fifo_empty. It then pulses info_fifo_rden for one cycle and latches the info byte.
  - If bit0=1, it goes to FWD only when good_fifo_afull=0 and ctrl_fifo_afull=0. Otherwise it holds in IDLE without popping.
  - If bit0=0, it goes to DROP immediately, with no afull check.
- FWD: data_fifo_rden = ~data_fifo_empty & ~good_fifo_afull, combinational.
  - Each popped beat is written to the good FIFO unchanged.
  - byte_cnt += popcount(tkeep). byte_cnt is 16 bits, cleared on IDLE→FWD, and saturates at 16'hFFFF.
  - Popping a beat with tlast=1 moves the FSM to STS.
- DROP: data_fifo_rden = ~data_fifo_empty.
  - Beats are discarded and nothing is written.
  - Popping tlast=1 increments rx_drop_cnt and returns to IDLE.
- STS: writes 4 words, one per cycle, each only when ctrl_fifo_afull=0. tkeep=4'hF on all words.
  - w0 = C_STS_TAG
  - w1 = {24'h0, info byte}
  - w2 = {16'h0, byte_cnt}
  - w3 = {16'h0, seq}, tlast=1
  - seq is a 16-bit frame sequence number. It starts at 0 after reset and increments after w3.
  - After w3 the block increments rx_good_cnt and returns to IDLE.
- Stall rules:
  - While data_fifo_empty=1 in FWD/DROP, the FSM holds with no pop.
  - A good frame's status words always follow its last data beat.
  - The ctrl FIFO never receives a record for a dropped frame.
- Reset mid-frame: the FSM goes to IDLE; byte_cnt, seq, and both counters go to 0; the partial frame is abandoned. The FIFOs are reset from the same source.

## Timing
- Reset values: data_fifo_rden=0, info_fifo_rden=0, good_fifo_wren=0, good_fifo_wdata=0, ctrl_fifo_wren=0, ctrl_fifo_wdata=0, rx_good_cnt=0, rx_drop_cnt=0.
- good_fifo_wdata/wren and ctrl_fifo_wdata/wren are registered: each write appears 1 cycle after the pop or decision cycle.
- Cycle N: info pop. Cycle N+1: earliest data pop. Cycle N+2: earliest good FIFO write.
- FWD sustains 1 beat/cycle while the data FIFO is non-empty and good_fifo_afull=0.
- The last data pop is at cycle L. w0 is written at L+2 at the earliest, and w3 at L+5.
- The next info pop is at L+5 at the earliest, i.e. the cycle after STS completes.
- Drop: tlast pop at cycle L; rx_drop_cnt updates at L+1; next info pop at L+1 at the earliest.
- Inter-frame overhead for a good frame is ≥5 cycles. The afull thresholds must leave at least 2 entries of margin for the registered write.

## Test plan
- Good frame, 3 beats, tkeep FF/FF/0F, FIFOs never afull:
  - good FIFO receives 3 identical beats, tlast on beat 3.
  - ctrl FIFO receives 5000_0000, 0000_00xx (info), 0000_0014, 0000_0000, tlast on the 4th word.
  - rx_good_cnt=1.
- Bad frame (info=8'h00), 4 beats, followed by a good 1-beat frame:
  - no good FIFO writes for the bad frame; rx_drop_cnt=1.
  - the good frame is forwarded with seq=0.
- good_fifo_afull asserted in IDLE with a good info byte pending:
  - no info pop until afull deasserts.
  - with a bad info byte pending instead, the frame is dropped immediately.
- good_fifo_afull toggled mid-FWD on alternate cycles, 8-beat frame:
  - data pops stop exactly on the afull cycles; all 8 beats are delivered in order; byte_cnt=64.
- ctrl_fifo_afull asserted during STS after w1:
  - w2 and w3 are held until deassert; no duplicate or lost status words.
- s2mm_reset asserted mid-FWD of a 10-beat frame:
  - all outputs and counters are 0 the next cycle; FSM is in IDLE; the next frame after reset gets seq=0.
